// File: rtl/prior_encoder_reg_pkg.sv
// Shared definitions for the registered priority encoder: mode encodings and
// the elaboration-time log2 used to size index fields.
package prior_encoder_reg_pkg;

    localparam logic PE_MODE_FIXED = 1'b0;
    localparam logic PE_MODE_RR    = 1'b1;

    // Ceiling log2. The while loop is bounded by the 32-bit argument width.
    function automatic int unsigned pe_clog2(input int unsigned value);
        int unsigned width;
        int unsigned rem;
        width = 0;
        rem   = value - 1;
        while (rem > 0) begin
            width = width + 1;
            rem   = rem >> 1;
        end
        return width;
    endfunction

endpackage

// File: rtl/prior_encoder_reg_pick.sv
// Rotated priority search: scans ptr, ptr-1, ... 0, N-1, ... ptr+1 and reports
// the first set candidate. Fixed mode is the same scan anchored at N-1.
module prior_pick
    import prior_encoder_reg_pkg::*;
#(
    parameter  int unsigned N     = 8,
    localparam int unsigned OUT_W = pe_clog2(N)
) (
    input  logic [N-1:0]     cand,
    input  logic [OUT_W-1:0] ptr,
    input  logic             mode,
    output logic             any,
    output logic [OUT_W-1:0] idx
);

    logic [OUT_W-1:0] start;

    // Walk from lowest to highest priority so the highest-priority hit is written last.
    always_comb begin
        start = (mode == PE_MODE_RR) ? ptr : OUT_W'(N - 1);
        any   = 1'b0;
        idx   = '0;
        for (int k = int'(N) - 1; k >= 0; k--) begin
            int               pos;
            logic [OUT_W-1:0] sel;
            pos = int'(start) - k;
            if (pos < 0) begin
                pos = pos + int'(N);
            end
            sel = OUT_W'(pos);
            if (cand[sel]) begin
                any = 1'b1;
                idx = sel;
            end
        end
    end

endmodule

// File: rtl/prior_encoder_reg.sv
// Registered N-input priority encoder: latches requests into a pending set and
// presents one winner at a time, held until acknowledged.
module prior_encoder_reg
    import prior_encoder_reg_pkg::*;
#(
    parameter  int unsigned N     = 8,
    localparam int unsigned OUT_W = pe_clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             mode,
    input  logic [N-1:0]     req,
    input  logic             flush,
    input  logic             ack,
    output logic             out_valid,
    output logic [OUT_W-1:0] out_idx,
    output logic             flag
);

    logic [N-1:0]     pending;
    logic [N-1:0]     pending_nxt;
    logic             out_valid_nxt;
    logic [OUT_W-1:0] out_idx_nxt;
    logic [OUT_W-1:0] ptr;
    logic [OUT_W-1:0] ptr_nxt;

    logic             accept;
    logic [N-1:0]     idx_onehot;
    logic [N-1:0]     masked;
    logic             idle_any;
    logic [OUT_W-1:0] idle_idx;
    logic             next_any;
    logic [OUT_W-1:0] next_idx;

    always_comb begin
        idx_onehot          = '0;
        idx_onehot[out_idx] = 1'b1;
    end

    assign accept = ack && out_valid;
    assign masked = pending & ~idx_onehot;

    // Idle load picks over the full pending set.
    prior_pick #(.N(N)) u_pick_idle (
        .cand (pending),
        .ptr  (ptr),
        .mode (mode),
        .any  (idle_any),
        .idx  (idle_idx)
    );

    // Back-to-back reload excludes the index being acknowledged this edge.
    prior_pick #(.N(N)) u_pick_next (
        .cand (masked),
        .ptr  (ptr),
        .mode (mode),
        .any  (next_any),
        .idx  (next_idx)
    );

    always_comb begin
        pending_nxt   = (pending & ~(accept ? idx_onehot : '0)) | (enable ? req : '0);
        out_valid_nxt = out_valid;
        out_idx_nxt   = out_idx;
        ptr_nxt       = ptr;

        if (!out_valid) begin
            if (idle_any) begin
                out_valid_nxt = 1'b1;
                out_idx_nxt   = idle_idx;
            end
        end else if (accept) begin
            out_valid_nxt = next_any;
            if (next_any) begin
                out_idx_nxt = next_idx;
            end
            if (mode == PE_MODE_RR) begin
                ptr_nxt = (out_idx == '0) ? OUT_W'(N - 1) : out_idx - OUT_W'(1);
            end
        end

        // Flush discards pending work and same-cycle requests but keeps ptr/out_idx.
        if (flush) begin
            pending_nxt   = '0;
            out_valid_nxt = 1'b0;
            out_idx_nxt   = out_idx;
            ptr_nxt       = ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending   <= '0;
            out_valid <= 1'b0;
            out_idx   <= '0;
            ptr       <= OUT_W'(N - 1);
        end else begin
            pending   <= pending_nxt;
            out_valid <= out_valid_nxt;
            out_idx   <= out_idx_nxt;
            ptr       <= ptr_nxt;
        end
    end

    assign flag = |pending;

endmodule

// File: tb/tb_prior_encoder_reg.sv
// Scoreboarded bench for prior_encoder_reg (N=8): directed scenarios plus a
// random run, each cycle checked against a behavioural reference.
module tb_prior_encoder_reg;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       mode;
    logic [7:0] req;
    logic       flush;
    logic       ack;
    logic       out_valid;
    logic [2:0] out_idx;
    logic       flag;

    typedef struct packed {
        logic       valid;
        logic [2:0] idx;
        logic       flag;
    } exp_t;

    exp_t sb[$];
    int   n_cmp;
    int   n_bad;

    // Reference state
    logic [7:0] m_pend;
    logic       m_valid;
    logic [2:0] m_idx;
    logic [2:0] m_ptr;

    prior_encoder_reg #(.N(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .mode      (mode),
        .req       (req),
        .flush     (flush),
        .ack       (ack),
        .out_valid (out_valid),
        .out_idx   (out_idx),
        .flag      (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void pick_ref(input logic [7:0] c, input logic [2:0] st,
                                     output logic any, output logic [2:0] ix);
        logic [2:0] j;
        j   = st;
        any = 1'b0;
        ix  = 3'd0;
        for (int n = 0; n < 8; n++) begin
            if (!any && c[j]) begin
                any = 1'b1;
                ix  = j;
            end
            j = j - 3'd1;
        end
    endfunction

    task automatic model_reset();
        m_pend  = 8'h00;
        m_valid = 1'b0;
        m_idx   = 3'd0;
        m_ptr   = 3'd7;
    endtask

    task automatic model_step(input logic en, input logic md, input logic [7:0] rq,
                              input logic fl, input logic ak);
        logic       acc;
        logic [7:0] oh;
        logic [7:0] np;
        logic       any;
        logic [2:0] ix;
        logic [2:0] st;
        acc = ak && m_valid;
        oh  = 8'h01 << m_idx;
        np  = (m_pend & ~(acc ? oh : 8'h00)) | (en ? rq : 8'h00);
        st  = md ? m_ptr : 3'd7;
        if (fl) begin
            np      = 8'h00;
            m_valid = 1'b0;
        end else if (!m_valid) begin
            pick_ref(m_pend, st, any, ix);
            if (any) begin
                m_valid = 1'b1;
                m_idx   = ix;
            end
        end else if (acc) begin
            pick_ref(m_pend & ~oh, st, any, ix);
            if (md) m_ptr = (m_idx == 3'd0) ? 3'd7 : m_idx - 3'd1;
            m_valid = any;
            if (any) m_idx = ix;
        end
        m_pend = np;
    endtask

    // Drive one cycle, push the expected post-edge outputs, then pop and compare.
    task automatic step(input string tag, input logic en, input logic md, input logic [7:0] rq,
                        input logic fl, input logic ak);
        exp_t e;
        exp_t got;
        enable = en;
        mode   = md;
        req    = rq;
        flush  = fl;
        ack    = ak;
        model_step(en, md, rq, fl, ak);
        e.valid = m_valid;
        e.idx   = m_idx;
        e.flag  = |m_pend;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk({tag, ".valid"}, 32'(out_valid), 32'(got.valid));
        chk({tag, ".idx"},   32'(out_idx),   32'(got.idx));
        chk({tag, ".flag"},  32'(flag),      32'(got.flag));
    endtask

    initial begin
        logic [2:0] rr_exp [9] = '{3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
        logic [2:0] fx_exp [4] = '{3'd7, 3'd6, 3'd7, 3'd6};
        logic       rmode;
        n_cmp  = 0;
        n_bad  = 0;
        rst_n  = 1'b0;
        enable = 1'b0;
        mode   = 1'b0;
        req    = 8'h00;
        flush  = 1'b0;
        ack    = 1'b0;
        model_reset();
        #12;
        chk("reset.valid", 32'(out_valid), 32'd0);
        chk("reset.idx",   32'(out_idx),   32'd0);
        chk("reset.flag",  32'(flag),      32'd0);
        rst_n = 1'b1;

        // Fixed priority: one-cycle request burst drained by a held ack.
        step("fix0", 1'b1, 1'b0, 8'h26, 1'b0, 1'b1);
        chk("fix.flag_e0", 32'(flag), 32'd1);
        step("fix1", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("fix.idx5", 32'(out_idx), 32'd5);
        step("fix2", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("fix.idx2", 32'(out_idx), 32'd2);
        step("fix3", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("fix.idx1", 32'(out_idx), 32'd1);
        step("fix4", 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("fix.drained", 32'({out_valid, flag}), 32'd0);

        // Enable gating
        for (int i = 0; i < 3; i++) step("gate_off", 1'b0, 1'b0, 8'h10, 1'b0, 1'b0);
        chk("gate.off", 32'({out_valid, flag}), 32'd0);
        step("gate_on", 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);
        step("gate_out", 1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("gate.idx4", 32'({out_valid, out_idx}), 32'h0C);
        step("gate_ack", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Stray ack, then set-over-clear on the presented index
        step("soc_set", 1'b1, 1'b0, 8'h08, 1'b0, 1'b0);
        step("stray", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("stray.idx3", 32'({out_valid, out_idx}), 32'h0B);
        step("soc_ack", 1'b1, 1'b0, 8'h08, 1'b0, 1'b1);
        chk("soc.bubble", 32'({out_valid, flag}), 32'd1);
        step("soc_again", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("soc.idx3", 32'({out_valid, out_idx}), 32'h0B);
        step("soc_done", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Fixed vs round-robin with all requests held
        step("ff_fix", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step("ff_fix", 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
            chk("ff_fix.seq", 32'(out_idx), 32'(fx_exp[i]));
        end
        step("ff_flush", 1'b1, 1'b0, 8'hFF, 1'b1, 1'b1);
        step("ff_rr", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) begin
            step("ff_rr", 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1);
            chk("ff_rr.seq", 32'(out_idx), 32'(rr_exp[i]));
        end
        step("rr_flush", 1'b0, 1'b1, 8'h00, 1'b1, 1'b0);

        // Flush with a presented index and a same-cycle request
        step("fl_set", 1'b1, 1'b0, 8'h81, 1'b0, 1'b0);
        step("fl_pres", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("fl.idx7", 32'({out_valid, out_idx}), 32'h0F);
        step("fl_do", 1'b1, 1'b0, 8'h02, 1'b1, 1'b0);
        chk("fl.after", 32'({out_valid, flag, out_idx}), 32'h07);
        step("fl_next", 1'b1, 1'b0, 8'h04, 1'b0, 1'b0);
        step("fl_next2", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("fl.idx2", 32'({out_valid, out_idx}), 32'h0A);
        step("fl_done", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Asynchronous reset while a grant is presented
        step("rst_set", 1'b1, 1'b0, 8'h20, 1'b0, 1'b0);
        step("rst_pres", 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("rst.idx5", 32'({out_valid, out_idx}), 32'h0D);
        #3;
        rst_n = 1'b0;
        #1;
        chk("rst.async", 32'({out_valid, out_idx, flag}), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        step("rst_ack", 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

        // Random traffic against the reference
        rmode = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 19) == 0) rmode = ~rmode;
            step("rand", $urandom_range(0, 3) != 0, rmode,
                 8'($urandom) & 8'($urandom),
                 $urandom_range(0, 31) == 0, 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
